serial_subtractor: RTL and testbench

- Bit-serial ripple-borrow subtractor: computes diff = a - b - bin over WIDTH bits, one bit per clock, LSB first.
- Companion to the combinational ripple-carry adder. It subtracts instead of adds and trades area for latency by reusing one full-subtractor cell across WIDTH cycles.
- Sits in the arithmetic datapath as a start/done coprocessor beside the adder.

---
 rtl/serial_subtractor.sv | 143 ++++++++++++++
 tb/tb_serial_subtractor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output ovf when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             load_c;
    logic             step_c;
    logic             finish_c;
    logic             d_c;
    logic             borrow_c;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // Full-subtractor cell shared across all bit positions
    always_comb begin
        d_c      = sa[0] ^ sb[0] ^ br;
        borrow_c = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        step_c    = 1'b0;
        finish_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    load_c    = 1'b1;
                end
            end
            S_RUN: begin
                step_c = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = S_DONE;
                    finish_c  = 1'b1;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    load_c    = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand shifters, borrow flop, result register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sa   <= '0;
            sb   <= '0;
            sr   <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            busy <= (state_nxt == S_RUN);
            done <= (state_nxt == S_DONE);
            if (load_c) begin
                sa  <= a;
                sb  <= b;
                br  <= bin;
                cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
`endif
            end else if (step_c) begin
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                br  <= borrow_c;
                sr  <= {d_c, sr[WIDTH-1:1]};
                cnt <= cnt + CW'(1);
                if (finish_c) begin
                    diff <= {d_c, sr[WIDTH-1:1]};
                    bout <= borrow_c;
`ifdef SERIAL_SUB_OVF_EN
                    // Final d_c is the result MSB
                    ovf  <= (a_msb != b_msb) && (d_c != a_msb);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4); ovf is checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   start_cyc = 0;
    exp_t sb_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an accepted start and push the reference result
    task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv);
        logic [W:0] full;
        exp_t       e;
        a     = av;
        b     = bv;
        bin   = binv;
        start = 1'b1;
        tick();
        start_cyc = cyc;
        start = 1'b0;
        full   = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, binv};
        e.diff = full[W-1:0];
        e.bout = full[W];
        e.ovf  = (av[W-1] != bv[W-1]) && (full[W-1] != av[W-1]);
        sb_q.push_back(e);
    endtask

    // Wait (bounded) for done, then compare against the scoreboard head
    task automatic wait_done(input string tag);
        int   n = 0;
        exp_t e;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_latency"}, 32'(cyc - start_cyc), 32'(W));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        e = (sb_q.size() != 0) ? sb_q.pop_front() : exp_t'(0);
        chk({tag, "_diff"}, 32'(diff), 32'(e.diff));
        chk({tag, "_bout"}, 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;

        // Asynchronous reset before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_no_done", 32'(done), 32'd0);
        end

        // Basic subtraction with busy profile
        do_start(4'd9, 4'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("basic_busy", 32'(busy), 32'd1);
            chk("basic_no_early_done", 32'(done), 32'd0);
            tick();
        end
        wait_done("basic");
        tick();
        chk("basic_done_pulse", 32'(done), 32'd0);
        chk("basic_diff_hold", 32'(diff), 32'd6);

        // Borrow and wrap
        do_start(4'd2, 4'd5, 1'b0);
        wait_done("wrap");
        do_start(4'd7, 4'd7, 1'b1);
        wait_done("eq_bin");
        do_start(4'd0, 4'd1, 1'b0);
        wait_done("zero_minus_one");

        // Ignored start during RUN, then back-to-back from DONE
        tick();
        do_start(4'd10, 4'd4, 1'b0);
        tick();
        chk("run_diff_hold", 32'(diff), 32'd15);
        a     = 4'd3;
        b     = 4'd3;
        bin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd15;
        wait_done("ignored_start");
        do_start(4'd1, 4'd0, 1'b0);
        wait_done("back_to_back");

        // Reset mid-operation aborts with no done
        tick();
        do_start(4'd15, 4'd1, 1'b0);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_diff", 32'(diff), 32'd0);
        chk("midrst_bout", 32'(bout), 32'd0);
        sb_q.delete();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("midrst_no_done", 32'(done), 32'd0);
        end
        do_start(4'd15, 4'd1, 1'b0);
        wait_done("after_reset");

        // Signed overflow cases (ovf compared only when the feature is built)
        do_start(4'b0111, 4'b1000, 1'b0);
        wait_done("ovf_pos");
        do_start(4'd3, 4'd1, 1'b0);
        wait_done("ovf_none");
        do_start(4'b1000, 4'b0001, 1'b0);
        wait_done("ovf_neg");

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
